// File: rtl/mirror_pkg.sv
// Shared constants and read-sequencer state type for the horizontal-mirror line controller.
// No logic, so no latency; no flow control.
package mirror_pkg;
    localparam int MIRROR_LINE_MAX = 640;
    localparam int MIRROR_ADDR_W   = 10;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;
endpackage

// File: rtl/mirror_line_if.sv
// Bundle between the mirror controller and its line-bank RAMs / pixel pipeline.
// Pure wiring: zero latency; no backpressure, the pixel stream is free-running.
interface mirror_line_if
    import mirror_pkg::*;
#(
    parameter int ADDR_W = MIRROR_ADDR_W
) ();
    logic              iCCD_DVAL;
    logic              iMIRROR_EN;
    logic              iCLR_ERR;
    logic [ADDR_W:0]   oWR_ADDR;
    logic              oWR_EN;
    logic [ADDR_W:0]   oRD_ADDR;
    logic              oRD_EN;
    logic              oCCD_DVAL;
    logic [ADDR_W-1:0] oLINE_LEN;
    logic              oOVERFLOW;
    logic              oCOLLIDE;

    modport master (
        input  iCCD_DVAL, iMIRROR_EN, iCLR_ERR,
        output oWR_ADDR, oWR_EN, oRD_ADDR, oRD_EN, oCCD_DVAL,
        output oLINE_LEN, oOVERFLOW, oCOLLIDE
    );

    modport slave (
        output iCCD_DVAL, iMIRROR_EN, iCLR_ERR,
        input  oWR_ADDR, oWR_EN, oRD_ADDR, oRD_EN, oCCD_DVAL,
        input  oLINE_LEN, oOVERFLOW, oCOLLIDE
    );
endinterface

// File: rtl/mirror_rd_seq.sv
// Replay sequencer: walks a stored line forward or reversed; first address 1 cycle after start,
// pixel valid 1 cycle after each address. No backpressure; a new start restarts the replay.
module mirror_rd_seq
    import mirror_pkg::*;
#(
    parameter int ADDR_W = MIRROR_ADDR_W
) (
    input  logic              iCCD_PIXCLK,
    input  logic              iRST_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] lineLen,
    input  logic              mirror,
    input  logic              bank,
    output logic [ADDR_W:0]   rdAddr,
    output logic              rdEn,
    output logic              pixVld,
    output logic              busy
);
    rd_state_t         state, stateNxt;
    logic [ADDR_W-1:0] rc, rcNxt;
    logic [ADDR_W-1:0] col;
    logic              rcLast;

    assign rcLast = (rc == lineLen - ADDR_W'(1));

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= IDLE;
            rc     <= '0;
            pixVld <= 1'b0;
        end else begin
            state  <= stateNxt;
            rc     <= rcNxt;
            pixVld <= rdEn;
        end
    end

    always_comb begin
        stateNxt = state;
        rcNxt    = rc;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNxt = READ;
                    rcNxt    = '0;
                end
            end
            READ: begin
                // A fresh line end abandons the current replay in favour of the newer bank.
                if (start) begin
                    rcNxt = '0;
                end else if (rcLast) begin
                    stateNxt = IDLE;
                    rcNxt    = '0;
                end else begin
                    rcNxt = rc + ADDR_W'(1);
                end
            end
            default: begin
                stateNxt = IDLE;
                rcNxt    = '0;
            end
        endcase
    end

    assign busy   = (state == READ);
    assign rdEn   = busy;
    assign col    = mirror ? (lineLen - ADDR_W'(1) - rc) : rc;
    assign rdAddr = rdEn ? {bank, col} : '0;
endmodule

// File: rtl/mirror_line_ctrl.sv
// Ping-pong line-bank controller for horizontal mirroring: writes with 0 latency, replays at E+1,
// pixel valid at E+2. No backpressure; overruns and mid-replay line ends are flagged, not stalled.
module mirror_line_ctrl
    import mirror_pkg::*;
#(
    parameter int LINE_MAX = MIRROR_LINE_MAX,
    parameter int ADDR_W   = MIRROR_ADDR_W
) (
    input  logic          iCCD_PIXCLK,
    input  logic          iRST_N,
    mirror_line_if.master bus
);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(LINE_MAX);

    logic [ADDR_W-1:0] wc;
    logic [ADDR_W-1:0] lineLen;
    logic              wbank;
    logic              rbank;
    logic              mirrorQ;
    logic              dvalQ;
    logic              overflow;
    logic              collide;
    logic              lineEnd;
    logic              wrFull;
    logic              ovfEvt;
    logic              colEvt;
    logic              rdBusy;

    assign lineEnd = dvalQ & ~bus.iCCD_DVAL;
    assign wrFull  = (wc == COL_MAX);
    assign ovfEvt  = bus.iCCD_DVAL & wrFull;
    assign colEvt  = lineEnd & rdBusy;

    // Gated by reset so the RAM write strobe is dead while reset is held, even with pixels arriving.
    assign bus.oWR_EN   = iRST_N & bus.iCCD_DVAL & ~wrFull;
    assign bus.oWR_ADDR = {wbank, wc};

    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            wc      <= '0;
            lineLen <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            mirrorQ <= 1'b0;
            dvalQ   <= 1'b0;
        end else begin
            dvalQ <= bus.iCCD_DVAL;
            if (lineEnd) begin
                lineLen <= wc;
                wc      <= '0;
                rbank   <= wbank;
                wbank   <= ~wbank;
                mirrorQ <= bus.iMIRROR_EN;
            end else if (bus.iCCD_DVAL && !wrFull) begin
                wc <= wc + ADDR_W'(1);
            end
        end
    end

    // Setting events take priority over a simultaneous clear.
    always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            overflow <= 1'b0;
            collide  <= 1'b0;
        end else begin
            if (ovfEvt)            overflow <= 1'b1;
            else if (bus.iCLR_ERR) overflow <= 1'b0;
            if (colEvt)            collide  <= 1'b1;
            else if (bus.iCLR_ERR) collide  <= 1'b0;
        end
    end

    mirror_rd_seq #(
        .ADDR_W (ADDR_W)
    ) u_rd_seq (
        .iCCD_PIXCLK (iCCD_PIXCLK),
        .iRST_N      (iRST_N),
        .start       (lineEnd),
        .lineLen     (lineLen),
        .mirror      (mirrorQ),
        .bank        (rbank),
        .rdAddr      (bus.oRD_ADDR),
        .rdEn        (bus.oRD_EN),
        .pixVld      (bus.oCCD_DVAL),
        .busy        (rdBusy)
    );

    assign bus.oLINE_LEN = lineLen;
    assign bus.oOVERFLOW = overflow;
    assign bus.oCOLLIDE  = collide;
endmodule

// File: tb/tb_mirror_line_ctrl.sv
// Randomized scoreboard bench for mirror_line_ctrl: a line-level model predicts every write,
// replay address and output-valid cycle; a negedge monitor pops and compares.
module tb_mirror_line_ctrl;
    import mirror_pkg::*;

    localparam int LMAX = MIRROR_LINE_MAX;

    typedef struct {
        int         cyc;
        logic       en;
        logic [10:0] addr;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    ev_t wq[$];
    ev_t rq[$];
    int  dq[$];

    bit  mWbank;
    bit  mOvf;
    bit  mCol;
    int  mLen;
    int  replayEnd;

    mirror_line_if ifc ();

    mirror_line_ctrl dut (
        .iCCD_PIXCLK (clk),
        .iRST_N      (rst_n),
        .bus         (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic m, input logic c);
        @(posedge clk);
        #1;
        ifc.iCCD_DVAL  = d;
        ifc.iMIRROR_EN = m;
        ifc.iCLR_ERR   = c;
    endtask

    task automatic model_reset();
        wq.delete();
        rq.delete();
        dq.delete();
        mWbank    = 1'b0;
        mOvf      = 1'b0;
        mCol      = 1'b0;
        mLen      = 0;
        replayEnd = -1;
    endtask

    // One line of len pixels followed by gap (>=2) blank cycles; mir is the value present at line end.
    task automatic send_line(input int len, input int gap, input bit mir);
        int  col;
        int  e;
        ev_t ev;
        bit  rb;
        col = 0;
        for (int i = 0; i < len; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            ev.cyc  = cyc;
            ev.en   = (col < LMAX);
            ev.addr = {mWbank, 10'(col)};
            wq.push_back(ev);
            if (col < LMAX) col++;
            else mOvf = 1'b1;
        end
        step(1'b0, mir, 1'b0);
        e  = cyc;
        rb = mWbank;
        if (e <= replayEnd) mCol = 1'b1;
        while (rq.size() > 0 && rq[$].cyc > e) void'(rq.pop_back());
        while (dq.size() > 0 && dq[$] > e + 1) void'(dq.pop_back());
        for (int k = 0; k < col; k++) begin
            ev.cyc  = e + 1 + k;
            ev.en   = 1'b1;
            ev.addr = {rb, 10'(mir ? (col - 1 - k) : k)};
            rq.push_back(ev);
            dq.push_back(e + 2 + k);
        end
        replayEnd = e + col;
        mLen      = col;
        mWbank    = ~mWbank;
        for (int g = 1; g < gap; g++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (g == 1) begin
                @(negedge clk);
                chk("line_len", int'(ifc.oLINE_LEN), mLen);
                chk("overflow", int'(ifc.oOVERFLOW), int'(mOvf));
                chk("collide", int'(ifc.oCOLLIDE), int'(mCol));
            end
        end
    endtask

    task automatic clear_err();
        step(1'b0, 1'b0, 1'b1);
        mOvf = 1'b0;
        mCol = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_overflow", int'(ifc.oOVERFLOW), int'(mOvf));
        chk("clr_collide", int'(ifc.oCOLLIDE), int'(mCol));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, int'(ifc.oWR_EN), 0);
        chk({tag, "_wr_addr"}, int'(ifc.oWR_ADDR), 0);
        chk({tag, "_rd_en"}, int'(ifc.oRD_EN), 0);
        chk({tag, "_rd_addr"}, int'(ifc.oRD_ADDR), 0);
        chk({tag, "_dval"}, int'(ifc.oCCD_DVAL), 0);
        chk({tag, "_line_len"}, int'(ifc.oLINE_LEN), 0);
        chk({tag, "_overflow"}, int'(ifc.oOVERFLOW), 0);
        chk({tag, "_collide"}, int'(ifc.oCOLLIDE), 0);
    endtask

    // Monitor: every DUT output event must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            ev_t e;
            if (ifc.oWR_EN || ifc.iCCD_DVAL) begin
                if (wq.size() == 0) chk("wr_unexpected", int'(ifc.oWR_EN), 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_en", int'(ifc.oWR_EN), int'(e.en));
                    chk("wr_addr", int'(ifc.oWR_ADDR), int'(e.addr));
                end
            end
            if (ifc.oRD_EN) begin
                if (rq.size() == 0) chk("rd_unexpected", int'(ifc.oRD_EN), 0);
                else begin
                    e = rq.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", int'(ifc.oRD_ADDR), int'(e.addr));
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("rd_missing", int'(ifc.oRD_EN), 1);
                void'(rq.pop_front());
            end
            if (ifc.oCCD_DVAL) begin
                if (dq.size() == 0) chk("dval_unexpected", int'(ifc.oCCD_DVAL), 0);
                else chk("dval_cycle", cyc, dq.pop_front());
            end else if (dq.size() > 0 && dq[0] <= cyc) begin
                chk("dval_missing", int'(ifc.oCCD_DVAL), 1);
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

    initial begin
        int len;
        int gap;
        int waited;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifc.iCCD_DVAL  = 1'b0;
        ifc.iMIRROR_EN = 1'b0;
        ifc.iCLR_ERR   = 1'b0;
        model_reset();

        // Reset held while pixels toggle: everything stays quiet.
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2 == 0), 1'b1, 1'b1);
            @(negedge clk);
            if (i < 2) chk_all_zero("reset");
        end
        step(1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Full-width mirrored line, then two short straight lines.
        send_line(LMAX, LMAX + 60, 1'b1);
        send_line(8, 4, 1'b0);
        send_line(8, 20, 1'b0);

        // Overrun by five pixels, then clear.
        send_line(LMAX + 5, LMAX + 20, 1'b0);
        clear_err();

        // Short line ending mid-replay of a full line.
        send_line(LMAX, 2, 1'($urandom_range(0, 1)));
        send_line(10, 30, 1'b1);
        clear_err();

        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(1, LMAX + 60);
            gap = $urandom_range(2, len + 20);
            send_line(len, gap, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clear_err();
        end
        send_line(12, LMAX + 20, 1'b0);

        // Reset 300 cycles into a replay: read side must go quiet without a clock edge.
        send_line(LMAX, 300, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd_en", int'(ifc.oRD_EN), 0);
        chk("arst_dval", int'(ifc.oCCD_DVAL), 0);
        model_reset();
        @(negedge clk);
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        send_line(20, 30, 1'b0);
        send_line(5, 10, 1'b1);

        waited = 0;
        while ((wq.size() + rq.size() + dq.size()) > 0 && waited < 2000) begin
            step(1'b0, 1'b0, 1'b0);
            waited++;
        end
        @(negedge clk);
        chk("drain", wq.size() + rq.size() + dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
